// File: rtl/gpo_cmd_pkg.sv
// Shared definitions for the GPO/GPI command link initiator:
// command codes, GPO word field positions, capture word count and FSM states.
package gpo_cmd_pkg;

    localparam logic [7:0] CMD_RESET       = 8'd0;
    localparam logic [7:0] CMD_EN_TX       = 8'd1;
    localparam logic [7:0] CMD_EN_RX       = 8'd2;
    localparam logic [7:0] CMD_PH_SEL      = 8'd3;
    localparam logic [7:0] CMD_RUN_MEM     = 8'd4;
    localparam logic [7:0] CMD_READ_MEM    = 8'd5;
    localparam logic [7:0] CMD_BER_I       = 8'd7;
    localparam logic [7:0] CMD_BER_Q       = 8'd8;
    localparam logic [7:0] CMD_IS_MEM_FULL = 8'd9;

    localparam int CMD_MSB  = 31;
    localparam int CMD_LSB  = 24;
    localparam int EN_BIT   = 23;
    localparam int DATA_MSB = 22;

    // Unknown codes behave as plain writes.
    function automatic logic [2:0] capture_words(input logic [7:0] cmd);
        case (cmd)
            CMD_READ_MEM, CMD_IS_MEM_FULL:                      capture_words = 3'd1;
            CMD_BER_I, CMD_BER_Q:                               capture_words = 3'd4;
            CMD_RESET, CMD_EN_TX, CMD_EN_RX, CMD_PH_SEL,
            CMD_RUN_MEM:                                        capture_words = 3'd0;
            default:                                            capture_words = 3'd0;
        endcase
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_WAIT    = 3'd4,
        ST_CAPTURE = 3'd5,
        ST_RESP    = 3'd6
    } state_t;

endpackage

// File: rtl/gpo_cycle_timer.sv
// Loadable down-counter that stops at zero; done is high while the count is zero.
module gpo_cycle_timer #(
    parameter int NB_CNT = 4
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              load,
    input  logic [NB_CNT-1:0] value,
    output logic              done
);

    logic [NB_CNT-1:0] cnt;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/gpo_cmd_master.sv
// Initiator for the 32-bit GPO/GPI command link: strobes one command onto the GPO
// word and, for read-type commands, gathers GPI words into a single response.
module gpo_cmd_master
    import gpo_cmd_pkg::*;
#(
    parameter int HOLD_CYC = 2,
    parameter int GAP_CYC  = 2,
    parameter int RD_LAT   = 2,
    parameter int NB_CNT   = 4
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic [7:0]   i_req_cmd,
    input  logic [22:0]  i_req_data,
    output logic [31:0]  o_gpo,
    input  logic [31:0]  i_gpi,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic [127:0] o_rsp_data,
    output logic [2:0]   o_rsp_nwords,
    output logic         o_busy,
    output logic [2:0]   o_dbg_state
);

    // Valid/ready: a request transfers on a cycle where i_req_valid and o_req_ready are both
    // high; a response transfers where o_rsp_valid and i_rsp_ready are both high. o_rsp_valid
    // and the response payload hold steady until that transfer.

    localparam logic [NB_CNT-1:0] HOLD_LD = NB_CNT'((HOLD_CYC > 1) ? HOLD_CYC - 1 : 0);
    localparam logic [NB_CNT-1:0] GAP_LD  = NB_CNT'((GAP_CYC > 1) ? GAP_CYC - 1 : 0);
    localparam logic [NB_CNT-1:0] WAIT_LD = NB_CNT'((RD_LAT > 1) ? RD_LAT - 1 : 0);

    state_t            state;
    logic [2:0]        tgt_words;
    logic              tmr_load;
    logic [NB_CNT-1:0] tmr_value;
    logic              tmr_done;

    gpo_cycle_timer #(.NB_CNT(NB_CNT)) u_timer (
        .clk   (clk),
        .i_rst (i_rst),
        .load  (tmr_load),
        .value (tmr_value),
        .done  (tmr_done)
    );

    // The timer is loaded on the cycle that leaves a phase, so it is primed on entry.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state)
            ST_SETUP: begin
                tmr_load  = 1'b1;
                tmr_value = HOLD_LD;
            end
            ST_STROBE: if (tmr_done) begin
                tmr_load  = 1'b1;
                tmr_value = GAP_LD;
            end
            ST_RELEASE: if (tmr_done) begin
                tmr_load  = 1'b1;
                tmr_value = WAIT_LD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            o_gpo        <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_data   <= '0;
            o_rsp_nwords <= '0;
            tgt_words    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (i_req_valid) begin
                    o_gpo[CMD_MSB:CMD_LSB] <= i_req_cmd;
                    o_gpo[EN_BIT]          <= 1'b0;
                    o_gpo[DATA_MSB:0]      <= i_req_data;
                    tgt_words              <= capture_words(i_req_cmd);
                    o_rsp_data             <= '0;
                    o_rsp_nwords           <= '0;
                    state                  <= ST_SETUP;
                end
                ST_SETUP: begin
                    o_gpo[EN_BIT] <= 1'b1;
                    state         <= ST_STROBE;
                end
                ST_STROBE: if (tmr_done) begin
                    o_gpo[EN_BIT] <= 1'b0;
                    state         <= ST_RELEASE;
                end
                ST_RELEASE: if (tmr_done) begin
                    if (tgt_words == 3'd0) begin
                        o_rsp_valid <= 1'b1;
                        state       <= ST_RESP;
                    end else if (RD_LAT == 0) begin
                        state <= ST_CAPTURE;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: if (tmr_done) begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    o_rsp_data[{o_rsp_nwords[1:0], 5'd0} +: 32] <= i_gpi;
                    o_rsp_nwords <= o_rsp_nwords + 3'd1;
                    if (o_rsp_nwords + 3'd1 == tgt_words) begin
                        o_rsp_valid <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: if (i_rsp_ready) begin
                    o_rsp_valid <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ready = (state == ST_IDLE);
    assign o_busy      = (state != ST_IDLE);
    assign o_dbg_state = state;

endmodule

// File: tb/tb_gpo_cmd_master.sv
// Bench for gpo_cmd_master: directed link scenarios plus random commands checked
// against a cycle-timeline model and a response scoreboard.
module tb_gpo_cmd_master;

    localparam int H  = 2;
    localparam int G  = 2;
    localparam int R  = 2;
    localparam int NB = 4;

    logic         clk = 1'b0;
    logic         i_rst;
    logic         i_req_valid;
    logic         o_req_ready;
    logic [7:0]   i_req_cmd;
    logic [22:0]  i_req_data;
    logic [31:0]  o_gpo;
    logic [31:0]  i_gpi;
    logic         o_rsp_valid;
    logic         i_rsp_ready;
    logic [127:0] o_rsp_data;
    logic [2:0]   o_rsp_nwords;
    logic         o_busy;
    logic [2:0]   o_dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [130:0] exp_q[$];
    logic [22:0]  seen_q[$];
    int   rise_cnt = 0;
    int   low_run  = 0;
    int   last_gap = 0;
    logic prev_en  = 1'b0;

    gpo_cmd_master #(.HOLD_CYC(H), .GAP_CYC(G), .RD_LAT(R), .NB_CNT(NB)) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_cmd    (i_req_cmd),
        .i_req_data   (i_req_data),
        .o_gpo        (o_gpo),
        .i_gpi        (i_gpi),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_data   (o_rsp_data),
        .o_rsp_nwords (o_rsp_nwords),
        .o_busy       (o_busy),
        .o_dbg_state  (o_dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int words_for(input logic [7:0] cmd);
        case (cmd)
            8'd5, 8'd9: words_for = 1;
            8'd7, 8'd8: words_for = 4;
            default:    words_for = 0;
        endcase
    endfunction

    // Enable-edge monitor (what the register file sees) and response scoreboard.
    always @(negedge clk) begin
        logic [130:0] e;
        if (o_gpo[23] && !prev_en) begin
            rise_cnt++;
            last_gap = low_run;
            seen_q.push_back(o_gpo[22:0]);
        end
        low_run = o_gpo[23] ? 0 : low_run + 1;
        prev_en = o_gpo[23];
        if (!i_rst && o_rsp_valid && i_rsp_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_rsp", 128'(o_rsp_valid), 128'(0));
            end else begin
                e = exp_q.pop_front();
                check_eq("sb_data", o_rsp_data, e[127:0]);
                check_eq("sb_nwords", 128'(o_rsp_nwords), 128'(e[130:128]));
            end
        end
    end

    task automatic do_cmd(input logic [7:0] cmd, input logic [22:0] data,
                          input logic [127:0] words, input int stall);
        int n, lat, cap0, w;
        logic [127:0] exp_data;
        logic [31:0]  exp_gpo;
        n = words_for(cmd);
        exp_data = '0;
        for (int k = 0; k < n; k++) exp_data[32*k +: 32] = words[32*k +: 32];
        cap0 = 1 + H + G + R;
        lat  = 1 + H + G + ((n > 0) ? R + n : 0);
        w = 0;
        while (!o_req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!o_req_ready) begin
            check_eq("req_ready_timeout", 128'(o_req_ready), 128'(1));
            return;
        end
        exp_q.push_back({3'(n), exp_data});
        i_req_valid = 1'b1;
        i_req_cmd   = cmd;
        i_req_data  = data;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        for (int t = 0; t < lat; t++) begin
            i_gpi = (n > 0 && t >= cap0) ? words[32*(t-cap0) +: 32] : $urandom;
            @(negedge clk);
            exp_gpo = {cmd, (t >= 1 && t <= H), data};
            check_eq("gpo_phase", 128'(o_gpo), 128'(exp_gpo));
            check_eq("rsp_valid_early", 128'(o_rsp_valid), 128'(0));
            check_eq("busy_active", 128'(o_busy), 128'(1));
            check_eq("req_ready_busy", 128'(o_req_ready), 128'(0));
            @(posedge clk); #1;
        end
        i_gpi       = $urandom;
        i_rsp_ready = (stall == 0);
        @(negedge clk);
        check_eq("rsp_valid", 128'(o_rsp_valid), 128'(1));
        check_eq("rsp_data", o_rsp_data, exp_data);
        check_eq("rsp_nwords", 128'(o_rsp_nwords), 128'(n));
        check_eq("gpo_after", 128'(o_gpo), 128'({cmd, 1'b0, data}));
        for (int s = 1; s <= stall; s++) begin
            @(posedge clk); #1;
            i_req_valid = (s < stall) ? 1'($urandom_range(0, 1)) : 1'b0;
            i_req_cmd   = 8'($urandom);
            i_rsp_ready = (s == stall);
            @(negedge clk);
            check_eq("stall_valid", 128'(o_rsp_valid), 128'(1));
            check_eq("stall_data", o_rsp_data, exp_data);
            check_eq("stall_req_ready", 128'(o_req_ready), 128'(0));
            check_eq("stall_gpo", 128'(o_gpo), 128'({cmd, 1'b0, data}));
        end
        @(posedge clk); #1;
        i_rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("rsp_dropped", 128'(o_rsp_valid), 128'(0));
        check_eq("idle_ready", 128'(o_req_ready), 128'(1));
        check_eq("idle_busy", 128'(o_busy), 128'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0;
        logic [7:0] rc;
        i_rst = 1'b1; i_req_valid = 1'b0; i_req_cmd = '0; i_req_data = '0;
        i_gpi = '0; i_rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        check_eq("rst_gpo", 128'(o_gpo), 128'(0));
        check_eq("rst_rsp_valid", 128'(o_rsp_valid), 128'(0));
        check_eq("rst_rsp_data", o_rsp_data, 128'(0));
        check_eq("rst_nwords", 128'(o_rsp_nwords), 128'(0));
        check_eq("rst_req_ready", 128'(o_req_ready), 128'(1));
        check_eq("rst_busy", 128'(o_busy), 128'(0));

        // Write: EN_TX with data 1.
        do_cmd(8'd1, 23'd1, '0, 0);
        // 1-word read at address 0x0123.
        do_cmd(8'd5, 23'h0123, 128'h0000_0000_0000_0000_0000_0000_CAFE_0123, 0);
        // 4-word read.
        do_cmd(8'd7, 23'd0, 128'h0000_0044_0000_0033_0000_0022_0000_0011, 1);

        // Back-to-back writes with response always accepted.
        seen_q.delete();
        r0 = rise_cnt;
        do_cmd(8'd3, 23'd2, '0, 0);
        do_cmd(8'd3, 23'd1, '0, 0);
        check_eq("b2b_edges", 128'(rise_cnt - r0), 128'(2));
        check_eq("b2b_gap_ok", 128'(last_gap >= G + 1), 128'(1));
        check_eq("b2b_first", 128'((seen_q.size() > 0) ? seen_q[0] : 23'h7fffff), 128'(2));
        check_eq("b2b_second", 128'((seen_q.size() > 1) ? seen_q[1] : 23'h7fffff), 128'(1));

        // Reset in the second STROBE cycle of a read.
        i_req_valid = 1'b1; i_req_cmd = 8'd8; i_req_data = 23'h55;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_gpo", 128'(o_gpo), 128'(0));
        check_eq("mid_rst_busy", 128'(o_busy), 128'(0));
        check_eq("mid_rst_ready", 128'(o_req_ready), 128'(1));
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check_eq("mid_rst_no_rsp", 128'(o_rsp_valid), 128'(0));
            check_eq("mid_rst_gpo_quiet", 128'(o_gpo), 128'(0));
        end

        // Read held in RESP for 10 cycles of backpressure.
        do_cmd(8'd5, 23'h1abc, {96'd0, 32'($urandom)}, 10);

        for (int i = 0; i < 24; i++) begin
            rc = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
            do_cmd(rc, 23'($urandom), {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)},
                   $urandom_range(0, 4));
        end

        repeat (3) @(negedge clk);
        check_eq("sb_leftover", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
